// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte/half/word data RAM with req/ready handshake and latency
// Range, alignment and funct3 checks; single-word debug tap.
module data_mem_ctrl #(
    parameter int DEPTH    = 128,
    parameter int LATENCY  = 1,
    parameter int TAP_WORD = 10,
    parameter int TAP_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             ready,
    output logic [31:0]      rdata,
    output logic             err,
    output logic [TAP_W-1:0] tap
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH];

    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata;
    logic [1:0]  lane;
    logic [AW-1:0] widx;
    logic        in_range, f3_ok, aligned, acc_err, commit;
    logic [3:0]  be;
    logic [31:0] wshift, rd_word, rd_shift, ld_data;
    logic [31:0] rdata_q;
    logic        err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // cnt holds the remaining WAIT edges; leaving at cnt==1 lands RESP in cycle LATENCY
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY <= 1) begin
                        state_nx = S_RESP;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) state_nx = S_RESP;
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == S_IDLE && req) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // With LATENCY=1 the commit edge is the capture edge, so use the live inputs in IDLE
    always_comb begin
        a_we    = (state == S_IDLE) ? we     : we_q;
        a_f3    = (state == S_IDLE) ? funct3 : f3_q;
        a_addr  = (state == S_IDLE) ? addr   : addr_q;
        a_wdata = (state == S_IDLE) ? wdata  : wdata_q;
    end

    assign commit   = (state != S_RESP) && (state_nx == S_RESP);
    assign lane     = a_addr[1:0];
    assign widx     = a_addr[AW+1:2];
    assign in_range = a_addr[31:2] < 30'(DEPTH);

    always_comb begin
        f3_ok   = 1'b0;
        aligned = 1'b1;
        case (a_f3)
            3'b000: f3_ok = 1'b1;
            3'b001: begin
                f3_ok   = 1'b1;
                aligned = !a_addr[0];
            end
            3'b010: begin
                f3_ok   = 1'b1;
                aligned = (lane == 2'b00);
            end
            3'b100: f3_ok = !a_we;
            3'b101: begin
                f3_ok   = !a_we;
                aligned = !a_addr[0];
            end
            default: f3_ok = 1'b0;
        endcase
    end

    assign acc_err = !f3_ok || !aligned || !in_range;

    always_comb begin
        be = 4'b1111;
        case (a_f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    assign wshift = a_wdata << {lane, 3'b000};

    // Gating on reset keeps a store from landing when reset is held across its commit edge
    always_ff @(posedge clk) begin
        if (reset && commit && a_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    assign rd_word  = mem[widx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        ld_data = rd_word;
        case (a_f3)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    // Response registers are loaded only at the commit edge, so they read zero outside RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || a_we) ? 32'd0 : ld_data;
        end else begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign busy  = (state != S_IDLE);
    assign ready = (state == S_RESP);
    assign rdata = rdata_q;
    assign err   = err_q;
    assign tap   = mem[TAP_WORD][TAP_W-1:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed vector bench for data_mem_ctrl at LATENCY 1 and 4
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_d;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;

    logic        busy1, ready1, err1, busy4, ready4, err4;
    logic [31:0] rdata1, rdata4;
    logic [3:0]  tap1, tap4;
    logic        r_busy, r_ready, r_err;
    logic [31:0] r_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(128), .LATENCY(1), .TAP_WORD(10), .TAP_W(4)) u1 (
        .clk(clk), .reset(reset), .req(req_d & ~sel), .we(we), .funct3(f3),
        .addr(addr), .wdata(wdata), .busy(busy1), .ready(ready1),
        .rdata(rdata1), .err(err1), .tap(tap1)
    );

    data_mem_ctrl #(.DEPTH(128), .LATENCY(4), .TAP_WORD(10), .TAP_W(4)) u4 (
        .clk(clk), .reset(reset), .req(req_d & sel), .we(we), .funct3(f3),
        .addr(addr), .wdata(wdata), .busy(busy4), .ready(ready4),
        .rdata(rdata4), .err(err4), .tap(tap4)
    );

    always_comb begin
        r_busy  = sel ? busy4  : busy1;
        r_ready = sel ? ready4 : ready1;
        r_err   = sel ? err4   : err1;
        r_rdata = sel ? rdata4 : rdata1;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] r, input logic e);
        vec_t v;
        v.we = w; v.f3 = f; v.addr = a; v.wdata = d; v.rd = r; v.er = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input int lat,
                          input logic [31:0] exp_rd, input logic exp_er);
        int n;
        @(posedge clk); #1;
        req_d = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        @(posedge clk); #1;
        req_d = 1'b0;
        n = 1;
        while (!r_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " rdata"}, r_rdata, exp_rd);
        check({tag, " err"}, {31'd0, r_err}, {31'd0, exp_er});
        @(posedge clk); #1;
        check({tag, " pulse"}, {30'd0, r_ready, r_busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] rmask, bmask;

        // LATENCY=1 vectors: {we, funct3, addr, wdata, expected rdata, expected err}
        add(1, 3'b010, 32'h28,  32'hDEADBEEF, 32'h0,        0);
        add(0, 3'b010, 32'h28,  32'h0,        32'hDEADBEEF, 0);
        add(1, 3'b010, 32'h40,  32'h11223344, 32'h0,        0);
        add(1, 3'b000, 32'h41,  32'h0000007F, 32'h0,        0);
        add(1, 3'b000, 32'h42,  32'h00000080, 32'h0,        0);
        add(0, 3'b000, 32'h42,  32'h0,        32'hFFFFFF80, 0);
        add(0, 3'b100, 32'h42,  32'h0,        32'h00000080, 0);
        add(0, 3'b010, 32'h40,  32'h0,        32'h11807F44, 0);
        add(0, 3'b000, 32'h41,  32'h0,        32'h0000007F, 0);
        add(0, 3'b101, 32'h40,  32'h0,        32'h00007F44, 0);
        add(1, 3'b010, 32'h42,  32'h99999999, 32'h0,        1);
        add(0, 3'b010, 32'h40,  32'h0,        32'h11807F44, 0);
        add(1, 3'b010, 32'h44,  32'h55667788, 32'h0,        0);
        add(1, 3'b001, 32'h46,  32'hABCD8001, 32'h0,        0);
        add(0, 3'b001, 32'h46,  32'h0,        32'hFFFF8001, 0);
        add(0, 3'b101, 32'h46,  32'h0,        32'h00008001, 0);
        add(0, 3'b001, 32'h45,  32'h0,        32'h0,        1);
        add(0, 3'b010, 32'h44,  32'h0,        32'h80017788, 0);
        add(0, 3'b001, 32'h44,  32'h0,        32'h00007788, 0);
        add(1, 3'b010, 32'h0,   32'hA5A5A5A5, 32'h0,        0);
        add(1, 3'b010, 32'h200, 32'hFFFFFFFF, 32'h0,        1);
        add(0, 3'b010, 32'h200, 32'h0,        32'h0,        1);
        add(0, 3'b010, 32'h0,   32'h0,        32'hA5A5A5A5, 0);
        add(0, 3'b011, 32'h0,   32'h0,        32'h0,        1);
        add(1, 3'b011, 32'h0,   32'h5A5A5A5A, 32'h0,        1);
        add(1, 3'b100, 32'h0,   32'h5A5A5A5A, 32'h0,        1);
        add(0, 3'b110, 32'h0,   32'h0,        32'h0,        1);
        add(0, 3'b010, 32'h0,   32'h0,        32'hA5A5A5A5, 0);
        add(1, 3'b000, 32'h29,  32'h00001234, 32'h0,        0);
        add(0, 3'b010, 32'h28,  32'h0,        32'hDEAD34EF, 0);
        add(0, 3'b010, 32'h80000000, 32'h0,   32'h0,        1);

        reset = 1'b0; sel = 1'b0; req_d = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {26'd0, busy1, ready1, err1, busy4, ready4, err4}, 32'd0);
        check("reset rdata1", rdata1, 32'd0);
        check("reset rdata4", rdata4, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            access($sformatf("v%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
                   vecs[i].wdata, 1, vecs[i].rd, vecs[i].er);
        end

        check("tap after word 10 writes", {28'd0, tap1}, 32'hF);
        access("sb tap", 1, 3'b000, 32'h28, 32'h00000003, 1, 32'h0, 0);
        check("tap after sb", {28'd0, tap1}, 32'h3);

        // LATENCY=4 with req held high: one acceptance per 5 cycles
        sel = 1'b1;
        rmask = '0;
        bmask = '0;
        @(posedge clk); #1;
        req_d = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0;
        for (int c = 1; c < 16; c++) begin
            @(posedge clk); #1;
            rmask[c] = ready4;
            bmask[c] = busy4;
        end
        req_d = 1'b0;
        check("held req ready mask", {16'd0, rmask}, 32'h4210);
        check("held req busy mask", {16'd0, bmask}, 32'h7BDE);
        repeat (6) @(posedge clk);

        access("l4 sw", 1, 3'b010, 32'h0, 32'hCAFEF00D, 4, 32'h0, 0);
        access("l4 lw", 0, 3'b010, 32'h0, 32'h0, 4, 32'hCAFEF00D, 0);

        // Reset in cycle 2 of an in-flight store
        @(posedge clk); #1;
        req_d = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0; wdata = 32'h12345678;
        @(posedge clk); #1;
        req_d = 1'b0;
        @(posedge clk); #1;
        check("busy before abort", {31'd0, busy4}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort flags", {29'd0, busy4, ready4, err4}, 32'd0);
        check("abort rdata", rdata4, 32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("tap kept over reset", {28'd0, tap1}, 32'h3);
        access("post abort lw", 0, 3'b010, 32'h0, 32'h0, 4, 32'hCAFEF00D, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
